// File: rtl/chdr_pkt_checker_pkg.sv
// Shared types, header field positions and error codes for the CHDR packet checker.
// Anything that unpacks or grades CHDR packets should import this package.
package chdr_pkt_checker_pkg;

  localparam int CHDR_HDR_BYTES = 8;
  localparam int CHDR_SEQ_W     = 12;

  localparam int HDR_FLAGS_MSB = 63;
  localparam int HDR_FLAGS_LSB = 60;
  localparam int HDR_SEQ_MSB   = 59;
  localparam int HDR_SEQ_LSB   = 48;
  localparam int HDR_LEN_MSB   = 47;
  localparam int HDR_LEN_LSB   = 32;
  localparam int HDR_SID_MSB   = 31;
  localparam int HDR_SID_LSB   = 0;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SEQ     = 3'd1;
  localparam logic [2:0] ERR_SID     = 3'd2;
  localparam logic [2:0] ERR_LEN_FMT = 3'd3;
  localparam logic [2:0] ERR_SHORT   = 3'd4;
  localparam logic [2:0] ERR_LONG    = 3'd5;
  localparam logic [2:0] ERR_PAYLOAD = 3'd6;

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]            flags;
    logic [CHDR_SEQ_W-1:0] seqnum;
    logic [15:0]           len;
    logic [31:0]           sid;
  } chdr_hdr_t;

  // A packet reports only its first error; later candidates are dropped.
  function automatic logic [2:0] keep_first_err(input logic [2:0] cur, input logic [2:0] cand);
    return (cur != ERR_NONE) ? cur : cand;
  endfunction

endpackage

// File: rtl/chdr_pkt_checker_if.sv
// 64-bit AXI-stream carrying CHDR beats; the checker uses the slave side.
interface chdr_pkt_checker_if;

  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);

endinterface

// File: rtl/chdr_pkt_checker_hdr_unpack.sv
// Combinational CHDR header splitter: fields, payload beat count and length-format flag.
// Kept separate so other CHDR sinks can share the same header decode.
module chdr_hdr_unpack
  import chdr_pkt_checker_pkg::*;
(
  input  logic [63:0] hdr_word,
  output chdr_hdr_t   hdr,
  output logic [15:0] exp_beats,
  output logic        len_fmt_err
);

  // Field extraction and derived length checks.
  always_comb begin
    hdr.flags  = hdr_word[HDR_FLAGS_MSB:HDR_FLAGS_LSB];
    hdr.seqnum = hdr_word[HDR_SEQ_MSB:HDR_SEQ_LSB];
    hdr.len    = hdr_word[HDR_LEN_MSB:HDR_LEN_LSB];
    hdr.sid    = hdr_word[HDR_SID_MSB:HDR_SID_LSB];
    // Length is in bytes including the header word, so payload beats = words - 1.
    exp_beats   = {3'b000, hdr_word[HDR_LEN_MSB:HDR_LEN_LSB+3]} - 16'd1;
    len_fmt_err = (hdr_word[HDR_LEN_LSB+2:HDR_LEN_LSB] != 3'b000) ||
                  (hdr_word[HDR_LEN_MSB:HDR_LEN_LSB] < 16'(2 * CHDR_HDR_BYTES));
  end

endmodule

// File: rtl/chdr_pkt_checker.sv
// CHDR data-packet sink: checks header, sequence, SID, length and payload pattern,
// and publishes a per-packet status strobe plus running packet/error counters.
module chdr_pkt_checker
  import chdr_pkt_checker_pkg::*;
#(
  parameter bit CHECK_PAYLOAD = 1'b1,
  parameter int SEQ_WIDTH     = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  chdr_pkt_checker_if.slave    s_axis,
  input  logic                 sid_check_en,
  input  logic [31:0]          expected_sid,
  output logic                 pkt_done_stb,
  output logic                 err_stb,
  output logic [2:0]           err_code,
  output logic [SEQ_WIDTH-1:0] last_seqnum,
  output logic [31:0]          pkt_count,
  output logic [15:0]          err_count
);

  state_t               state_q, state_d;
  logic [SEQ_WIDTH-1:0] prev_seq_q, prev_seq_d;
  logic                 seq_valid_q, seq_valid_d;
  logic [SEQ_WIDTH-1:0] cur_seq_q, cur_seq_d;
  logic [15:0]          exp_beats_q, exp_beats_d;
  logic [15:0]          beat_cnt_q, beat_cnt_d;
  logic [63:0]          base_q, base_d;
  logic [2:0]           code_q, code_d;
  logic                 done_q, done_d;
  logic                 err_stb_q, err_stb_d;
  logic [2:0]           err_code_q, err_code_d;
  logic [SEQ_WIDTH-1:0] last_seqnum_q, last_seqnum_d;
  logic [31:0]          pkt_count_q, pkt_count_d;
  logic [15:0]          err_count_q, err_count_d;

  chdr_hdr_t            hdr_s;
  logic [15:0]          hdr_exp_beats_s;
  logic                 hdr_len_fmt_s;
  logic                 accept_s;
  logic [SEQ_WIDTH-1:0] seq_expect_s;
  logic [2:0]           hdr_err_s;
  logic                 pay_err_s;
  logic [2:0]           pay_code_s;
  logic [15:0]          cnt_next_s;
  logic                 complete_s;
  logic [2:0]           final_code_s;
  logic [SEQ_WIDTH-1:0] final_seq_s;
  logic                 unused_flags_s;

  chdr_hdr_unpack u_hdr_unpack (
    .hdr_word    (s_axis.tdata),
    .hdr         (hdr_s),
    .exp_beats   (hdr_exp_beats_s),
    .len_fmt_err (hdr_len_fmt_s)
  );

  // Pure sink: only the reset/clear cycle ever holds off the stream.
  assign s_axis.tready  = ~(reset | clear);
  assign accept_s       = s_axis.tvalid & s_axis.tready;
  assign seq_expect_s   = prev_seq_q + {{(SEQ_WIDTH-1){1'b0}}, 1'b1};
  assign cnt_next_s     = beat_cnt_q + 16'd1;
  assign unused_flags_s = &{1'b0, hdr_s.flags};

  // Grade the current beat: header error, payload error and packet completion.
  always_comb begin
    if (hdr_len_fmt_s) begin
      hdr_err_s = ERR_LEN_FMT;
    end else if (sid_check_en && (hdr_s.sid != expected_sid)) begin
      hdr_err_s = ERR_SID;
    end else if (seq_valid_q && (SEQ_WIDTH'(hdr_s.seqnum) != seq_expect_s)) begin
      hdr_err_s = ERR_SEQ;
    end else begin
      hdr_err_s = ERR_NONE;
    end
    pay_err_s    = CHECK_PAYLOAD && (beat_cnt_q != 16'd0) &&
                   (s_axis.tdata != (base_q + {48'd0, beat_cnt_q}));
    pay_code_s   = keep_first_err(code_q, pay_err_s ? ERR_PAYLOAD : ERR_NONE);
    complete_s   = 1'b0;
    final_code_s = ERR_NONE;
    final_seq_s  = cur_seq_q;
    if (accept_s && s_axis.tlast) begin
      complete_s = 1'b1;
      case (state_q)
        S_HDR: begin
          final_code_s = keep_first_err(hdr_err_s, ERR_SHORT);
          final_seq_s  = SEQ_WIDTH'(hdr_s.seqnum);
        end
        S_PAYLOAD: begin
          if (cnt_next_s < exp_beats_q) begin
            final_code_s = keep_first_err(pay_code_s, ERR_SHORT);
          end else begin
            final_code_s = pay_code_s;
          end
        end
        S_DRAIN:  final_code_s = code_q;
        default:  complete_s   = 1'b0;
      endcase
    end else begin
      complete_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= S_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: transitions happen only on accepted beats.
  always_comb begin
    state_d = state_q;
    if (accept_s) begin
      case (state_q)
        S_HDR: begin
          if (s_axis.tlast) begin
            state_d = S_HDR;
          end else if (hdr_len_fmt_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (s_axis.tlast) begin
            state_d = S_HDR;
          end else if (cnt_next_s == exp_beats_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_DRAIN: state_d = s_axis.tlast ? S_HDR : S_DRAIN;
        default: state_d = S_HDR;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and status outputs computed from the graded beat.
  always_comb begin
    prev_seq_d    = prev_seq_q;
    seq_valid_d   = seq_valid_q;
    cur_seq_d     = cur_seq_q;
    exp_beats_d   = exp_beats_q;
    beat_cnt_d    = beat_cnt_q;
    base_d        = base_q;
    code_d        = code_q;
    done_d        = 1'b0;
    err_stb_d     = 1'b0;
    err_code_d    = err_code_q;
    last_seqnum_d = last_seqnum_q;
    pkt_count_d   = pkt_count_q;
    err_count_d   = err_count_q;
    if (accept_s) begin
      case (state_q)
        S_HDR: begin
          // Sequence tracking advances even on error so one gap reports once.
          cur_seq_d   = SEQ_WIDTH'(hdr_s.seqnum);
          prev_seq_d  = SEQ_WIDTH'(hdr_s.seqnum);
          seq_valid_d = 1'b1;
          exp_beats_d = hdr_exp_beats_s;
          beat_cnt_d  = 16'd0;
          code_d      = hdr_err_s;
        end
        S_PAYLOAD: begin
          if (beat_cnt_q == 16'd0) begin
            base_d = s_axis.tdata;
          end else begin
            base_d = base_q;
          end
          beat_cnt_d = cnt_next_s;
          if (!s_axis.tlast && (cnt_next_s == exp_beats_q)) begin
            code_d = keep_first_err(pay_code_s, ERR_LONG);
          end else begin
            code_d = pay_code_s;
          end
        end
        S_DRAIN: code_d = code_q;
        default: code_d = code_q;
      endcase
    end else begin
      code_d = code_q;
    end
    if (complete_s) begin
      done_d        = 1'b1;
      err_stb_d     = (final_code_s != ERR_NONE);
      err_code_d    = final_code_s;
      last_seqnum_d = final_seq_s;
      pkt_count_d   = pkt_count_q + 32'd1;
      if ((final_code_s != ERR_NONE) && (err_count_q != 16'hFFFF)) begin
        err_count_d = err_count_q + 16'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Datapath and status registers; clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_seq_q    <= '0;
      seq_valid_q   <= 1'b0;
      cur_seq_q     <= '0;
      exp_beats_q   <= 16'd0;
      beat_cnt_q    <= 16'd0;
      base_q        <= 64'd0;
      code_q        <= ERR_NONE;
      done_q        <= 1'b0;
      err_stb_q     <= 1'b0;
      err_code_q    <= ERR_NONE;
      last_seqnum_q <= '0;
      pkt_count_q   <= 32'd0;
      err_count_q   <= 16'd0;
    end else begin
      prev_seq_q    <= prev_seq_d;
      seq_valid_q   <= seq_valid_d;
      cur_seq_q     <= cur_seq_d;
      exp_beats_q   <= exp_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      base_q        <= base_d;
      code_q        <= code_d;
      done_q        <= done_d;
      err_stb_q     <= err_stb_d;
      err_code_q    <= err_code_d;
      last_seqnum_q <= last_seqnum_d;
      pkt_count_q   <= pkt_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign pkt_done_stb = done_q;
  assign err_stb      = err_stb_q;
  assign err_code     = err_code_q;
  assign last_seqnum  = last_seqnum_q;
  assign pkt_count    = pkt_count_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_chdr_pkt_checker.sv
// Scoreboard bench for chdr_pkt_checker: expected packet results are queued as the
// final beat is driven and compared when pkt_done_stb fires.
module tb_chdr_pkt_checker;

  typedef struct packed {
    logic [2:0]  code;
    logic [11:0] seq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        sid_check_en = 1'b1;
  logic [31:0] expected_sid = 32'h0000_0001;
  logic        pkt_done_stb, err_stb;
  logic [2:0]  err_code;
  logic [11:0] last_seqnum;
  logic [31:0] pkt_count;
  logic [15:0] err_count;

  int   total = 0;
  int   bad = 0;
  int   exp_pkts = 0;
  int   exp_errs = 0;
  int   ready_low = 0;
  exp_t sb_q[$];

  chdr_pkt_checker_if axis ();

  chdr_pkt_checker #(.CHECK_PAYLOAD(1'b1), .SEQ_WIDTH(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .s_axis       (axis.slave),
    .sid_check_en (sid_check_en),
    .expected_sid (expected_sid),
    .pkt_done_stb (pkt_done_stb),
    .err_stb      (err_stb),
    .err_code     (err_code),
    .last_seqnum  (last_seqnum),
    .pkt_count    (pkt_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (axis.tvalid && !axis.tready) ready_low++;
      if (pkt_done_stb) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_stb", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("err_code", {61'd0, err_code}, {61'd0, e.code});
          check_val("err_stb", {63'd0, err_stb}, {63'd0, (e.code != 3'd0)});
          check_val("last_seqnum", {52'd0, last_seqnum}, {52'd0, e.seq});
        end
      end
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic l);
    axis.tdata  = d;
    axis.tlast  = l;
    axis.tvalid = 1'b1;
    @(posedge clk);
    #1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  // One packet: header then npay payload words base+k (word bad_idx corrupted).
  task automatic send_pkt(input logic [11:0] seq, input logic [31:0] sid, input logic [15:0] len,
                          input int npay, input logic [63:0] base, input int bad_idx,
                          input logic [2:0] code);
    exp_t e;
    logic [63:0] w;
    e.code = code;
    e.seq  = seq;
    if (npay == 0) begin
      sb_q.push_back(e);
      exp_pkts++;
      if (code != 3'd0) exp_errs++;
    end
    drive_beat({4'h0, seq, len, sid}, (npay == 0));
    for (int k = 0; k < npay; k++) begin
      w = base + 64'(k);
      if (k == bad_idx) w = w ^ 64'h0000_0100_0000_0000;
      if (k == npay - 1) begin
        sb_q.push_back(e);
        exp_pkts++;
        if (code != 3'd0) exp_errs++;
      end
      drive_beat(w, (k == npay - 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    idle(3);
    check_val({tag, "_pkt_count"}, {32'd0, pkt_count}, 64'(exp_pkts));
    check_val({tag, "_err_count"}, {48'd0, err_count}, 64'(exp_errs));
    check_val({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic pulse_rst(input logic use_clear);
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    @(negedge clk);
    check_val("tready_in_rst", {63'd0, axis.tready}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear = 1'b0;
    exp_pkts = 0;
    exp_errs = 0;
    sb_q.delete();
  endtask

  logic [63:0] bases [7];

  initial begin
    axis.tdata  = 64'd0;
    axis.tlast  = 1'b0;
    axis.tvalid = 1'b0;
    bases = '{64'hAAAA_AAAA_0000_0000, 64'h8888_8888_0000_0000, 64'h7777_7777_0000_0000,
              64'h6666_6666_0000_0000, 64'h5555_5555_0000_0000, 64'h3333_3333_0000_0000,
              64'h2222_2222_0000_0000};
    idle(2);
    pulse_rst(1'b0);
    @(negedge clk);
    check_val("rst_tready", {63'd0, axis.tready}, 64'd1);
    check_val("rst_stb", {62'd0, pkt_done_stb, err_stb}, 64'd0);
    check_val("rst_code", {61'd0, err_code}, 64'd0);
    check_val("rst_seq", {52'd0, last_seqnum}, 64'd0);
    check_val("rst_pkts", {32'd0, pkt_count}, 64'd0);
    @(posedge clk);
    #1;

    // Good stream, back to back.
    for (int i = 0; i < 7; i++) send_pkt(12'(i), 32'h1, 16'd2008, 250, bases[i], -1, 3'd0);
    check_counters("good");
    check_val("good_last_seq", {52'd0, last_seqnum}, 64'd6);

    // Sequence wrap is legal; a gap reports once.
    pulse_rst(1'b1);
    send_pkt(12'd4094, 32'h1, 16'd40, 4, 64'h10, -1, 3'd0);
    send_pkt(12'd4095, 32'h1, 16'd40, 4, 64'h20, -1, 3'd0);
    send_pkt(12'd0,    32'h1, 16'd40, 4, 64'h30, -1, 3'd0);
    send_pkt(12'd2,    32'h1, 16'd40, 4, 64'h40, -1, 3'd1);
    send_pkt(12'd3,    32'h1, 16'd40, 4, 64'h50, -1, 3'd0);
    check_counters("seq");

    // Short, long, then clean.
    send_pkt(12'd4, 32'h1, 16'd2008, 100, 64'h1000, -1, 3'd4);
    send_pkt(12'd5, 32'h1, 16'd24,   5,   64'h2000, -1, 3'd5);
    send_pkt(12'd6, 32'h1, 16'd40,   4,   64'h3000, -1, 3'd0);
    check_counters("len");

    // Header error outranks payload error; payload error visible without SID check.
    send_pkt(12'd7, 32'h2, 16'd2008, 250, 64'hDEAD_0000_0000_0000, 17, 3'd2);
    sid_check_en = 1'b0;
    send_pkt(12'd8, 32'h2, 16'd2008, 250, 64'hBEEF_0000_0000_0000, 17, 3'd6);
    sid_check_en = 1'b1;
    check_counters("pay");

    // Bad length format, header-only packet, minimal single-beat payload.
    send_pkt(12'd9,  32'h1, 16'd2009, 3, 64'h4000, -1, 3'd3);
    send_pkt(12'd10, 32'h1, 16'd16,   0, 64'h0,    -1, 3'd4);
    send_pkt(12'd11, 32'h1, 16'd16,   1, 64'h5000, -1, 3'd0);
    check_counters("fmt");

    // Reset mid-packet: abandoned packet never strobes, sequence tracking restarts.
    drive_beat({4'h0, 12'd12, 16'd2008, 32'h1}, 1'b0);
    for (int k = 0; k < 49; k++) drive_beat(64'h6000 + 64'(k), 1'b0);
    pulse_rst(1'b0);
    send_pkt(12'd9, 32'h1, 16'd40, 4, 64'h7000, -1, 3'd0);
    check_counters("abort");
    check_val("abort_last_seq", {52'd0, last_seqnum}, 64'd9);

    check_val("tready_never_low", 64'(ready_low), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chdr_pkt_checker.md
Name: chdr_pkt_checker

Overview:
- Streaming sink that consumes CHDR data packets on a 64-bit AXI-stream, i.e. the str_sink side of a noc_shell.
- Per packet it validates the header, sequence continuity, SID, beat count against the header length, and an incrementing payload pattern.
- Publishes per-packet status strobes and running counters.
- Used as the receiving end of the data-packet generator in noc_shell/crossbar benches, and as a bring-up monitor in hardware.

Parameters:
- CHECK_PAYLOAD, 1, when 1 each payload word must equal first payload word + beat index (mod 2^64); when 0 the payload check is disabled.
- SEQ_WIDTH, 12, sequence number width; fixed by CHDR, not overridable in practice.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous; same effect as reset on counters, state and sequence tracking.
- i_tdata  in  64  CHDR beat; header = {flags[63:60], seqnum[59:48], len[47:32] bytes incl. 8-byte header, sid[31:0]}.
- i_tlast  in  1  last beat of packet.
- i_tvalid  in  1  beat valid.
- i_tready  out  1  beat accepted when i_tvalid & i_tready.
- sid_check_en  in  1  enables SID comparison.
- expected_sid  in  32  SID every packet must carry when sid_check_en=1.
- pkt_done_stb  out  1  one-cycle pulse per packet completed.
- err_stb  out  1  one-cycle pulse, coincident with pkt_done_stb, when the completed packet had an error.
- err_code  out  3  code of the first error in the last completed packet; 0 = none.
- last_seqnum  out  12  seqnum of the last completed packet.
- pkt_count  out  32  packets completed; wraps.
- err_count  out  16  erroneous packets; saturates at 16'hFFFF.

Behaviour:
- Reset/clear:
  - i_tready=0 during the reset/clear cycle, 1 from the next cycle; never deasserted otherwise (pure sink).
  - All strobes, counters, err_code and last_seqnum = 0.
  - FSM returns to S_HDR; seq_valid flag cleared.
  - Reset or clear mid-packet abandons the packet without a strobe; the next accepted beat is treated as a header.
- FSM states: S_HDR, S_PAYLOAD, S_DRAIN. All transitions occur only on accepted beats.
- S_HDR, on an accepted beat:
  - Latch seqnum and sid.
  - exp_beats = len[15:3] - 1 (payload beats).
  - Record the first error, priority LEN_FMT(3) > SID(2) > SEQ(1):
    - LEN_FMT: len[2:0] != 0 or len < 16.
    - SID: sid_check_en and sid != expected_sid.
    - SEQ: seq_valid and seqnum != (prev_seq + 1) mod 4096; the 4095->0 wrap is legal.
  - Update prev_seq <= seqnum and set seq_valid, even on error, so a single gap reports once.
  - If tlast is also set: SHORT(4) unless an error is already recorded; packet completes.
  - If LEN_FMT and no tlast: go to S_DRAIN.
  - Otherwise: go to S_PAYLOAD with beat_cnt=0.
- S_PAYLOAD, per accepted beat:
  - beat_cnt==0: capture base = tdata.
  - beat_cnt>0 and CHECK_PAYLOAD: tdata != base + beat_cnt gives PAYLOAD(6).
  - beat_cnt increments every beat (16 bits).
  - tlast with beat_cnt+1 < exp_beats: SHORT(4); complete.
  - tlast with beat_cnt+1 == exp_beats: complete.
  - beat_cnt+1 == exp_beats without tlast: LONG(5); go to S_DRAIN.
  - Only the first error per packet is kept; later errors are ignored.
- S_DRAIN: discard beats until tlast, then complete.
- Completion:
  - The cycle after the tlast beat: pkt_done_stb=1; err_stb=(code!=0); err_code and last_seqnum updated; pkt_count+1; err_count+1 if error (saturating).
  - Latency from tlast acceptance to strobe: exactly 1 cycle.
  - Back-to-back packets (header immediately after tlast) are supported at full rate with no bubble.
- Single-beat payload (len=16): base captured only, no pattern check.

Decomposition:
- Shared include chdr_pkt_checker_defs.vh holds:
  - Error-code localparams ERR_NONE..ERR_PAYLOAD (0-6).
  - Header field bit positions (flags, seqnum, len, sid).
  - Header length constant CHDR_HDR_BYTES=8.
- One natural combinational sub-module: chdr_hdr_unpack.
  - Splits the header into fields.
  - Computes exp_beats and the LEN_FMT flag.
  - Reusable by other CHDR sinks.
- FSM, counters and payload checker stay in the top module.

Test Plan:
- Good stream: 7 packets, seq 0..6, sid 32'h0000_0001, len field 16'd2008 (250 beats), payloads 64'hAAAA_AAAA_0000_0000+k ... 64'h2222_2222_0000_0000+k, tvalid continuous -> 7 pkt_done_stb, pkt_count=7, err_count=0, last_seqnum=6, i_tready never low.
- Sequence gap and wrap: seq 4094, 4095, 0, then 2 -> no error for the wrap; 4th packet err_code=1; next packet seq 3 gives no error; err_count=1.
- Length mismatch:
  - Header len=2008 with tlast on beat 100 -> err_code=4.
  - Header len=24 with 5 payload beats -> err_code=5, drained through tlast, pkt_done_stb once.
  - Following good packet -> clean.
- Corrupt payload word 17 of a 250-beat packet while sid also mismatches with sid_check_en=1 -> err_code=2 (header error wins); with sid_check_en=0 -> err_code=6.
- Bad format: len=16'd2009 -> err_code=3; header with tlast and len=16 -> err_code=4.
- Reset mid-packet after 50 beats, then a fresh packet seq 9 -> no strobe for the aborted packet; seq 9 accepted without SEQ error; pkt_count=1.
